// File: rtl/cla_pkg.sv
// Shared definitions for the nibble-serial carry-lookahead adder: FSM states,
// nibble size and the nibble-index width helper.
package cla_pkg;

  localparam int NIBBLE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed to index WIDTH/4 nibbles, never less than one.
  function automatic int idx_width(input int width);
    int w;
    w = $clog2(width / NIBBLE);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/cla4_slice.sv
// Combinational 4-bit carry-lookahead slice. c3 is the carry into the top bit,
// used for two's-complement overflow detection.
module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co,
  output logic       c3
);

  logic [3:0] p;
  logic [3:0] g;
  logic       c1;
  logic       c2;

  assign p = a ^ b;
  assign g = a & b;

  // Every carry is a flat sum of products of g/p/ci, so no carry waits on another.
  assign c1 = g[0] | (p[0] & ci);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
  assign co = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & ci);

  assign s = p ^ {c3, c2, c1, ci};

endmodule

// File: rtl/cla_nibble_seq.sv
// Sequential adder reusing one cla4_slice over WIDTH/4 cycles.
// Define CLA_SEQ_OVF_FLAG_EN to add the registered two's-complement ovf output.
module cla_nibble_seq
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef CLA_SEQ_OVF_FLAG_EN
  output logic             ovf,
`endif
  output logic             busy
);

  localparam int IW = idx_width(WIDTH);
  localparam logic [IW-1:0] LAST = IW'(WIDTH / NIBBLE - 1);

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high; the producer holds its data until then, in_ready is high only in IDLE,
  // and out_valid holds sum/cout steady from DONE entry until the consumer takes it.
  state_t           state;
  logic [IW-1:0]    idx;
  logic             carry;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             out_valid_q;

  logic [3:0] a_nib;
  logic [3:0] b_nib;
  logic [3:0] s_nib;
  logic       co_nib;

  assign a_nib = a_q[idx*NIBBLE +: NIBBLE];
  assign b_nib = b_q[idx*NIBBLE +: NIBBLE];

`ifdef CLA_SEQ_OVF_FLAG_EN
  logic c3_nib;
  logic ovf_q;
  assign ovf = ovf_q;
`else
  logic c3_unused;
`endif

  cla4_slice u_slice (
    .a  (a_nib),
    .b  (b_nib),
    .ci (carry),
    .s  (s_nib),
    .co (co_nib),
`ifdef CLA_SEQ_OVF_FLAG_EN
    .c3 (c3_nib)
`else
    .c3 (c3_unused)
`endif
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      carry       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef CLA_SEQ_OVF_FLAG_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            carry <= cin;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum_q[idx*NIBBLE +: NIBBLE] <= s_nib;
          carry <= co_nib;
          idx   <= idx + 1'b1;
          if (idx == LAST) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
            cout_q      <= co_nib;
`ifdef CLA_SEQ_OVF_FLAG_EN
            ovf_q       <= c3_nib ^ co_nib;
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_cla_nibble_seq.sv
// Directed bench for cla_nibble_seq at WIDTH=16; checks ovf too when
// CLA_SEQ_OVF_FLAG_EN is defined.
module tb_cla_nibble_seq;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
`ifdef CLA_SEQ_OVF_FLAG_EN
  logic             ovf;
`endif

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  // {ovf, cout, sum}
  logic [WIDTH+1:0] exp_q[$];

  cla_nibble_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
`ifdef CLA_SEQ_OVF_FLAG_EN
    .ovf       (ovf),
`endif
    .busy      (busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] ta,
                                             input logic [WIDTH-1:0] tb,
                                             input logic tc);
    logic [WIDTH:0] s;
    logic           v;
    s = {1'b0, ta} + {1'b0, tb} + {{WIDTH{1'b0}}, tc};
    v = (ta[WIDTH-1] == tb[WIDTH-1]) && (s[WIDTH-1] != ta[WIDTH-1]);
    return {v, s};
  endfunction

  // driver tasks: all called and returning at a falling edge
  task automatic start_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                          input logic tc);
    check("in_ready_before_accept", in_ready, 1);
    in_valid = 1'b1;
    a = ta;
    b = tb;
    cin = tc;
    exp_q.push_back(model(ta, tb, tc));
    @(negedge clk);
    in_valid = 1'b0;
    a = 16'(($urandom));
    b = 16'(($urandom));
    cin = 1'($urandom_range(0, 1));
  endtask

  // Returns the cycle in which out_valid was seen, the accepting cycle being 1.
  task automatic wait_done(output int cyc);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) check("out_valid_timeout", 0, 1);
    cyc = n + 1;
  endtask

  task automatic check_result(input string tag);
    logic [WIDTH+1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_exp_empty"}, 0, 1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_sum"}, 32'(sum), 32'(e[WIDTH-1:0]));
      check({tag, "_cout"}, 32'(cout), 32'(e[WIDTH]));
`ifdef CLA_SEQ_OVF_FLAG_EN
      check({tag, "_ovf"}, 32'(ovf), 32'(e[WIDTH+1]));
`endif
    end
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid_after_take", out_valid, 0);
    check("in_ready_after_take", in_ready, 1);
  endtask

  initial begin
    int cyc;
    int last_cyc;
    int results;
    int accepts;
    logic [WIDTH-1:0] held_sum;
    logic             held_cout;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic             rc;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_sum", sum, 0);
    check("reset_cout", cout, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_busy", busy, 0);
`ifdef CLA_SEQ_OVF_FLAG_EN
    check("reset_ovf", ovf, 0);
`endif
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_reset", in_ready, 1);

    // basic add with latency
    start_op(16'h1234, 16'h1111, 1'b0);
    check("busy_in_run", busy, 1);
    check("in_ready_in_run", in_ready, 0);
    wait_done(cyc);
    check("latency_1234", cyc, 5);
    check("sum_1234_const", sum, 32'h2345);
    check_result("add_1234");
    finish_op();

    // carry across every nibble
    start_op(16'hFFFF, 16'h0001, 1'b0);
    wait_done(cyc);
    check("sum_ffff_const", {cout, sum}, 32'h10000);
    check_result("add_ffff");
    finish_op();

    // signed overflow into the sign bit
    start_op(16'h7FFF, 16'h0001, 1'b0);
    wait_done(cyc);
    check("sum_7fff_const", {cout, sum}, 32'h08000);
    check_result("add_7fff");
    finish_op();

    // back-pressure in DONE while new operands wait
    start_op(16'hA5A5, 16'h5A5A, 1'b1);
    wait_done(cyc);
    check("sum_a5a5_const", {cout, sum}, 32'h10000);
    held_sum = sum;
    held_cout = cout;
    in_valid = 1'b1;
    a = 16'h0F0F;
    b = 16'h0101;
    cin = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_sum_stable", sum, 32'(held_sum));
      check("bp_cout_stable", cout, 32'(held_cout));
      check("bp_in_ready", in_ready, 0);
    end
    check_result("add_a5a5");
    exp_q.push_back(model(16'h0F0F, 16'h0101, 1'b0));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_in_ready_after_take", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    a = 16'hDEAD;
    b = 16'hBEEF;
    check("bp_second_busy", busy, 1);
    wait_done(cyc);
    check("latency_second", cyc, 5);
    check("sum_0f0f_const", {cout, sum}, 32'h01010);
    check_result("add_0f0f");
    finish_op();

    // reset during the second RUN cycle aborts silently
    start_op(16'h4321, 16'h1234, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b0;
    void'(exp_q.pop_back());
    check("abort_busy", busy, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_sum", sum, 0);
    check("abort_in_ready", in_ready, 1);
    results = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) results++;
    end
    check("abort_no_out_valid_pulse", results, 0);
    start_op(16'h00FF, 16'h0001, 1'b1);
    wait_done(cyc);
    check("sum_00ff_const", {cout, sum}, 32'h00101);
    check_result("add_00ff");
    finish_op();

    // streaming with both handshakes held high
    in_valid = 1'b1;
    out_ready = 1'b1;
    results = 0;
    accepts = 0;
    last_cyc = -1;
    for (int c = 0; c < 200 && results < 8; c++) begin
      if (out_valid) begin
        check_result("stream");
        if (last_cyc >= 0) check("stream_period", c - last_cyc, 6);
        last_cyc = c;
        results++;
      end
      if (in_ready && accepts < 8) begin
        ra = 16'($urandom);
        rb = 16'($urandom);
        rc = 1'($urandom_range(0, 1));
        a = ra;
        b = rb;
        cin = rc;
        exp_q.push_back(model(ra, rb, rc));
        accepts++;
      end else if (accepts >= 8) begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("stream_results", results, 8);
    check("stream_queue_empty", exp_q.size(), 0);

    // final report
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/cla_nibble_seq.md
CLA_NIBBLE_SEQ -- requirements
Module: cla_nibble_seq

Interface
REQ-001 Parameter: WIDTH, default 16, operand/sum width in bits; SHALL be a multiple of 4 and at least 4.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  operand transfer request.
REQ-005 in_ready  output  1  block can accept operands.
REQ-006 a  input  WIDTH  addend A.
REQ-007 b  input  WIDTH  addend B.
REQ-008 cin  input  1  carry into bit 0.
REQ-009 out_valid  output  1  result held and valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 sum  output  WIDTH  registered A+B+cin, low WIDTH bits.
REQ-012 cout  output  1  registered carry out of bit WIDTH-1.
REQ-013 busy  output  1  high whenever state is not IDLE.

Function
REQ-014 FSM states SHALL be IDLE, RUN and DONE only; one shared 4-bit lookahead slice is time-multiplexed across nibbles.
REQ-015 IDLE: in_ready=1; on in_valid&&in_ready, SHALL register a, b and cin, clear nibble index, load carry register with cin, and go to RUN.
REQ-016 RUN: each cycle, slice SHALL add nibble[idx] of A and B plus carry register; the result nibble SHALL be written to sum[4*idx+3:4*idx], carry register SHALL take the slice carry-out, and idx SHALL increment.
REQ-017 RUN with idx==WIDTH/4-1: after the write, SHALL go to DONE with cout equal to the final carry; WIDTH=4 gives exactly one RUN cycle.
REQ-018 Latency: out_valid SHALL rise exactly WIDTH/4+1 rising edges after the accepting edge (cycle 5 for WIDTH=16).
REQ-019 DONE: out_valid=1; sum and cout SHALL stay constant until out_valid&&out_ready, then the FSM SHALL go to IDLE.
REQ-020 in_ready SHALL be 0 in RUN and DONE; in_valid there SHALL be ignored, with no bypass from DONE to RUN. Back-to-back period is WIDTH/4+2 cycles.
REQ-021 Operand inputs SHALL be sampled only at the accepting edge; later changes SHALL not affect the result.
REQ-022 Arithmetic is unsigned modulo 2^WIDTH, and {cout,sum} SHALL equal a+b+cin exactly.
REQ-023 Slice SHALL compute per-bit p=a^b, g=a&b, and lookahead carries c(i+1)=g(i)|p(i)&c(i) expanded two-level, not rippled.

Reset
REQ-024 When rst is high at a rising edge, the next state SHALL be: FSM=IDLE, out_valid=0, sum=0, cout=0, idx=0, carry register=0, operand registers=0.
REQ-025 rst in RUN or DONE SHALL abort the transaction silently, with no out_valid pulse, and rst SHALL take priority over any handshake in the same cycle.
REQ-026 in_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-027 Macro CLA_SEQ_OVF_FLAG_EN defined: SHALL add output port ovf (1 bit), registered at DONE entry as the carry into bit WIDTH-1 XOR cout (two's-complement overflow), reset to 0, held like sum.
REQ-028 Macro undefined: SHALL have no ovf port, no ovf logic, and all other behaviour identical.

Structure
REQ-029 Shared package cla_pkg SHALL hold the FSM state enum typedef, the constant NIBBLE=4, and an index-width helper that yields $clog2(WIDTH/4), minimum 1.
REQ-030 Sub-module cla4_slice SHALL contain the combinational slice (inputs a[3:0], b[3:0], ci; outputs s[3:0], co, c3 for ovf), instantiated exactly once.

Verification (WIDTH=16)
REQ-031 Input a=0x1234, b=0x1111, cin=0 SHALL give sum=0x2345, cout=0, with out_valid in cycle 5 after accept.
REQ-032 Input a=0xFFFF, b=0x0001, cin=0 SHALL give sum=0x0000, cout=1, with carry crossing all nibbles; with the macro defined, ovf=0.
REQ-033 Input a=0x7FFF, b=0x0001, cin=0 SHALL give sum=0x8000, cout=0, and ovf=1 when the macro is defined.
REQ-034 Holding out_ready=0 for 10 cycles in DONE while in_valid=1 with new operands SHALL keep sum/cout stable and in_ready=0; after out_ready=1 the second operand set SHALL be accepted and computed correctly.
REQ-035 rst pulsed during the 2nd RUN cycle SHALL give IDLE, out_valid=0 and sum=0 next cycle; the following 0x00FF+0x0001, cin=1, SHALL give sum=0x0101, cout=0.
REQ-036 in_valid and out_ready held high continuously with random operands SHALL give one result every 6 cycles, each matching a+b+cin.
